// File: rtl/sa_stream_ctrl_pkg.sv
// ----------------------------------------------------------------------------
// sa_stream_ctrl_pkg
// Shared definitions for the systolic-array stream controller:
//   - state_e      : controller FSM states
//   - DEF_LEN_W    : default width of the beat count
//   - drain_cnt_w  : width of the drain counter for a given column count
// ----------------------------------------------------------------------------
package sa_stream_ctrl_pkg;

    localparam int unsigned DEF_LEN_W = 8;

    typedef enum logic [1:0] {
        StIdle,
        StStream,
        StDrain,
        StDone
    } state_e;

    // Drain counter must hold 0..COL-1; clog2(COL+1) keeps it >= 1 bit for COL=1.
    function automatic int unsigned drain_cnt_w(input int unsigned col);
        return (col < 1) ? 1 : $clog2(col + 1);
    endfunction

endpackage

// File: rtl/sa_wren_skew.sv
// ----------------------------------------------------------------------------
// sa_wren_skew
// COL-stage shift register that skews the column write enable: stage k is the
// input delayed k+1 cycles. A synchronous clear empties every stage.
// Ports:
//   i_clk    clock
//   i_rst_n  asynchronous active-low reset
//   i_clr    synchronous clear of all stages
//   i_in     bit entering stage 0
//   o_wren   stage outputs, bit k = stage k
// ----------------------------------------------------------------------------
module sa_wren_skew
    import sa_stream_ctrl_pkg::*;
#(
    parameter int unsigned COL = 3
) (
    input  logic           i_clk,
    input  logic           i_rst_n,
    input  logic           i_clr,
    input  logic           i_in,
    output logic [COL-1:0] o_wren
);

    logic [COL-1:0] r_sr;
    logic [COL:0]   w_shift;

    // Concatenation form keeps COL=1 legal (no [COL-2:0] slice).
    assign w_shift = {r_sr, i_in};

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_sr <= '0;
        end else if (i_clr) begin
            r_sr <= '0;
        end else begin
            r_sr <= w_shift[COL-1:0];
        end
    end

    assign o_wren = r_sr;

endmodule

// File: rtl/sa_stream_ctrl.sv
// ----------------------------------------------------------------------------
// sa_stream_ctrl
// Sequences one streaming pass of the systolic array: pops i_len beats from the
// operand FIFO, produces skewed per-column write enables, waits COL cycles for
// the last beat to reach the final column, then pulses o_done.
// Ports:
//   i_clk, i_rst_n  clock, asynchronous active-low reset
//   i_start, i_len  start strobe and beat count (sampled in IDLE only)
//   i_abort         synchronous abort of a pass in STREAM/DRAIN
//   i_fifo_empty    upstream FIFO empty flag
//   o_fifo_rd       FIFO pop (combinational)
//   o_col_wren      skewed column write enables
//   o_busy          high in STREAM and DRAIN
//   o_done          one-cycle pulse on normal completion
//   o_err           one-cycle pulse on an illegal command
// ----------------------------------------------------------------------------
module sa_stream_ctrl
    import sa_stream_ctrl_pkg::*;
#(
    parameter int unsigned COL   = 3,
    parameter int unsigned LEN_W = DEF_LEN_W
) (
    input  logic             i_clk,
    input  logic             i_rst_n,
    input  logic             i_start,
    input  logic [LEN_W-1:0] i_len,
    input  logic             i_abort,
    input  logic             i_fifo_empty,
    output logic             o_fifo_rd,
    output logic [COL-1:0]   o_col_wren,
    output logic             o_busy,
    output logic             o_done,
    output logic             o_err
);

    localparam int unsigned      DrainW    = drain_cnt_w(COL);
    localparam logic [DrainW-1:0] DrainLast = DrainW'(COL - 1);
    localparam logic [LEN_W-1:0]  LenOne    = LEN_W'(1);

    state_e             r_state;
    logic [LEN_W-1:0]   r_len;
    logic [LEN_W-1:0]   r_beat;
    logic [DrainW-1:0]  r_drain;
    logic               r_busy;
    logic               r_done;
    logic               r_err;

    logic               w_active;
    logic               w_abort;
    logic               w_fifo_rd;

    assign w_active  = (r_state == StStream) || (r_state == StDrain);
    assign w_abort   = i_abort && w_active;
    assign w_fifo_rd = (r_state == StStream) && !i_fifo_empty && !i_abort;

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_state <= StIdle;
            r_len   <= '0;
            r_beat  <= '0;
            r_drain <= '0;
            r_busy  <= 1'b0;
            r_done  <= 1'b0;
            r_err   <= 1'b0;
        end else begin
            r_done <= 1'b0;
            // Zero length in IDLE, or any start outside IDLE, is flagged; the
            // current pass carries on untouched.
            r_err  <= i_start && ((r_state != StIdle) || (i_len == '0));

            unique case (r_state)
                StIdle: begin
                    if (i_start && (i_len != '0)) begin
                        r_len   <= i_len;
                        r_beat  <= '0;
                        r_state <= StStream;
                        r_busy  <= 1'b1;
                    end
                end
                StStream: begin
                    if (w_abort) begin
                        r_state <= StIdle;
                        r_busy  <= 1'b0;
                    end else if (w_fifo_rd) begin
                        r_beat <= r_beat + LenOne;
                        // Compare against len-1 so len = 2^LEN_W-1 never wraps.
                        if (r_beat == r_len - LenOne) begin
                            r_state <= StDrain;
                            r_drain <= '0;
                        end
                    end
                end
                StDrain: begin
                    if (w_abort) begin
                        r_state <= StIdle;
                        r_busy  <= 1'b0;
                    end else if (r_drain == DrainLast) begin
                        r_state <= StDone;
                        r_busy  <= 1'b0;
                        r_done  <= 1'b1;
                    end else begin
                        r_drain <= r_drain + 1'b1;
                    end
                end
                StDone: begin
                    r_state <= StIdle;
                end
                default: begin
                    r_state <= StIdle;
                    r_busy  <= 1'b0;
                end
            endcase
        end
    end

    sa_wren_skew #(
        .COL (COL)
    ) u_skew (
        .i_clk   (i_clk),
        .i_rst_n (i_rst_n),
        .i_clr   (w_abort),
        .i_in    (w_fifo_rd),
        .o_wren  (o_col_wren)
    );

    assign o_fifo_rd = w_fifo_rd;
    assign o_busy    = r_busy;
    assign o_done    = r_done;
    assign o_err     = r_err;

endmodule

// File: tb/tb_sa_stream_ctrl.sv
// ----------------------------------------------------------------------------
// tb_sa_stream_ctrl
// Directed bench for sa_stream_ctrl (COL=3, LEN_W=8). Each scenario is a
// per-cycle stimulus table plus hand-computed expected windows for o_fifo_rd,
// o_busy, o_done and o_err; the expected write enables are the expected reads
// delayed k+1 cycles, zeroed for anything in flight when an abort hits.
// ----------------------------------------------------------------------------
module tb_sa_stream_ctrl;

    localparam int unsigned COL   = 3;
    localparam int unsigned LEN_W = 8;

    logic             clk;
    logic             rst_n;
    logic             start;
    logic [LEN_W-1:0] len;
    logic             abort;
    logic             fifo_empty;
    logic             fifo_rd;
    logic [COL-1:0]   col_wren;
    logic             busy;
    logic             done;
    logic             err;

    sa_stream_ctrl #(
        .COL   (COL),
        .LEN_W (LEN_W)
    ) dut (
        .i_clk        (clk),
        .i_rst_n      (rst_n),
        .i_start      (start),
        .i_len        (len),
        .i_abort      (abort),
        .i_fifo_empty (fifo_empty),
        .o_fifo_rd    (fifo_rd),
        .o_col_wren   (col_wren),
        .o_busy       (busy),
        .o_done       (done),
        .o_err        (err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_cmp = 0;
    int n_bad = 0;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        if (obs !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h want %0h", tag, obs, exp);
        end
    endtask

    // Scenario tables, indexed by cycle relative to the scenario start.
    logic [63:0]      s_start, s_empty, s_abort;
    logic [LEN_W-1:0] s_len [64];
    logic [63:0]      e_rd, e_busy, e_done, e_err;
    int               abort_c;

    function automatic logic [63:0] rng(input int a, input int b);
        logic [63:0] m;
        m = '0;
        for (int i = a; i <= b; i++) m[i] = 1'b1;
        return m;
    endfunction

    task automatic clr_scn();
        s_start = '0;
        s_empty = '0;
        s_abort = '0;
        for (int i = 0; i < 64; i++) s_len[i] = '0;
        e_rd    = '0;
        e_busy  = '0;
        e_done  = '0;
        e_err   = '0;
        abort_c = -1;
    endtask

    // Called just after a rising edge; returns just after a rising edge.
    task automatic run_scn(input string tag, input int n);
        logic [COL-1:0] ew;
        logic [6:0]     obs;
        logic [6:0]     exp;
        int             src;
        for (int c = 0; c < n; c++) begin
            #1;
            start      = s_start[c];
            len        = s_len[c];
            fifo_empty = s_empty[c];
            abort      = s_abort[c];
            @(negedge clk);
            for (int k = 0; k < int'(COL); k++) begin
                src   = c - 1 - k;
                ew[k] = (src >= 0) && e_rd[src] &&
                        !((abort_c >= 0) && (c > abort_c) && (src < abort_c));
            end
            obs = {fifo_rd, col_wren, busy, done, err};
            exp = {e_rd[c], ew, e_busy[c], e_done[c], e_err[c]};
            check($sformatf("%s c%0d {rd,wren,busy,done,err}", tag, c), 32'(obs), 32'(exp));
            @(posedge clk);
        end
        #1;
        start      = 1'b0;
        len        = '0;
        fifo_empty = 1'b0;
        abort      = 1'b0;
    endtask

    task automatic scn_basic();
        clr_scn();
        s_start[10] = 1'b1;
        s_len[10]   = 8'd4;
        e_rd        = rng(11, 14);
        e_busy      = rng(11, 17);
        e_done      = rng(18, 18);
    endtask

    int n_rd;
    int n_w2;
    int n_done;
    int done_at;

    initial begin
        rst_n      = 1'b0;
        start      = 1'b0;
        len        = '0;
        abort      = 1'b0;
        fifo_empty = 1'b0;
        #2;
        check("reset outputs", 32'({fifo_rd, col_wren, busy, done, err}), 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk);

        // Plain pass, len 4.
        scn_basic();
        run_scn("basic", 22);

        // Single-cycle FIFO empty bubble in cycle 12.
        scn_basic();
        s_empty[12] = 1'b1;
        e_rd        = rng(11, 11) | rng(13, 15);
        e_busy      = rng(11, 18);
        e_done      = rng(19, 19);
        run_scn("bubble", 23);

        // Zero-length command.
        clr_scn();
        s_start[10] = 1'b1;
        s_len[10]   = 8'd0;
        e_err       = rng(11, 11);
        run_scn("len0", 16);

        // Start re-issued during STREAM.
        scn_basic();
        s_start[12] = 1'b1;
        s_len[12]   = 8'd7;
        e_err       = rng(13, 13);
        run_scn("restart", 22);

        // Abort at 13, fresh start at 15.
        clr_scn();
        s_start[10] = 1'b1;
        s_len[10]   = 8'd4;
        s_abort[13] = 1'b1;
        s_start[15] = 1'b1;
        s_len[15]   = 8'd4;
        abort_c     = 13;
        e_rd        = rng(11, 12) | rng(16, 19);
        e_busy      = rng(11, 13) | rng(16, 22);
        e_done      = rng(23, 23);
        run_scn("abort", 26);

        // Abort while IDLE has no effect on a following pass.
        scn_basic();
        s_abort[5] = 1'b1;
        run_scn("idle_abort", 22);

        // Async reset in the middle of DRAIN (cycles 15..17).
        scn_basic();
        run_scn("pre_rst", 16);
        #3;
        rst_n = 1'b0;
        #1;
        check("async reset mid-drain", 32'({fifo_rd, col_wren, busy, done, err}), 32'd0);
        @(negedge clk);
        check("held in reset", 32'({fifo_rd, col_wren, busy, done, err}), 32'd0);
        rst_n = 1'b1;
        @(posedge clk);

        // Full-length pass, len 255: start in cycle 0, done expected at 255+3+1.
        #1;
        start = 1'b1;
        len   = 8'd255;
        @(posedge clk);
        #1;
        start   = 1'b0;
        len     = '0;
        n_rd    = 0;
        n_w2    = 0;
        n_done  = 0;
        done_at = -1;
        for (int i = 1; i < 300; i++) begin
            @(negedge clk);
            if (fifo_rd) n_rd++;
            if (col_wren[COL-1]) n_w2++;
            if (done) begin
                n_done++;
                done_at = i;
            end
            @(posedge clk);
        end
        check("len255 reads", 32'(n_rd), 32'd255);
        check("len255 last-column enables", 32'(n_w2), 32'd255);
        check("len255 done count", 32'(n_done), 32'd1);
        check("len255 done cycle", 32'(done_at), 32'd259);
        @(negedge clk);
        check("len255 back to idle", 32'({fifo_rd, col_wren, busy, done, err}), 32'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule

// File: doc/sa_stream_ctrl.md
Name: sa_stream_ctrl

Overview:
- Sequences one streaming pass of the systolic array.
- Accepts a start command carrying a beat count and pops that many beats from the upstream operand FIFO.
- Generates the skewed per-column write enables: column k fires k cycles after column 0.
- Waits for the last beat to reach the final column, then reports completion. Sits between the command/FIFO side and the array column registers.

Parameters:
- COL, 3, number of array columns (width of the skewed write-enable bus), >=1
- LEN_W, 8, width of the beat-count input and the internal beat counter

Ports:
- i_clk  input  1  clock; all state updates on rising edge
- i_rst_n  input  1  asynchronous active-low reset
- i_start  input  1  single-cycle command strobe; sampled only in IDLE
- i_len  input  LEN_W  beats to stream; sampled with i_start
- i_abort  input  1  synchronous abort of the current pass
- i_fifo_empty  input  1  upstream FIFO empty flag
- o_fifo_rd  output  1  FIFO pop; FIFO data valid the cycle after
- o_col_wren  output  COL  skewed column write enables; bit k = bit 0 delayed k cycles
- o_busy  output  1  high in STREAM and DRAIN
- o_done  output  1  one-cycle pulse on normal completion
- o_err  output  1  one-cycle pulse on an illegal command

Behaviour:
- Reset (async, i_rst_n=0): state=IDLE; beat and drain counters=0; o_col_wren=0; o_busy=0, o_done=0, o_err=0. Reset mid-pass discards the pass with no o_done. o_fifo_rd=0 combinationally while in IDLE.
- States: IDLE, STREAM, DRAIN, DONE.
- IDLE:
  - i_start=1 and i_len!=0 -> latch len, clear beat counter, go to STREAM next cycle.
  - i_start=1 and i_len==0 -> stay in IDLE, o_err=1 next cycle.
- o_fifo_rd = (state==STREAM) & !i_fifo_empty & !i_abort (combinational).
- STREAM:
  - Each cycle with o_fifo_rd=1 increments the beat counter.
  - A read while counter==len-1 transitions to DRAIN next cycle.
  - FIFO empty inserts a bubble: no read, no count, and a 0 enters the skew chain.
- Skew chain:
  - o_col_wren[0] <= o_fifo_rd.
  - o_col_wren[k] <= o_col_wren[k-1] for k=1..COL-1.
  - 1-cycle latency per column; bubbles propagate unchanged.
- DRAIN:
  - Lasts exactly COL cycles, counted by the drain counter.
  - Then DONE; o_done=1 for that one cycle, o_busy=0.
  - DONE -> IDLE next cycle.
- Timing, start at cycle T with no stalls:
  - o_fifo_rd high T+1..T+L.
  - o_col_wren[k] high T+2+k..T+L+1+k.
  - o_done at T+L+COL+1.
- i_start in any state other than IDLE -> ignored, o_err pulses the next cycle; the current pass is unaffected.
- i_abort in STREAM or DRAIN:
  - o_fifo_rd=0 that cycle.
  - Skew chain cleared synchronously: all o_col_wren=0 next cycle.
  - Next state IDLE; no o_done.
- i_abort in IDLE or DONE: no effect.
- Simultaneous i_abort and i_start in IDLE: start wins.
- Beat counter never wraps: the maximum len is 2^LEN_W-1, and the comparison is against len-1.
- COL=1: drain lasts 1 cycle; the skew chain is a single flop.

Decomposition:
- Shared package holds:
  - state enum (IDLE, STREAM, DRAIN, DONE);
  - default LEN_W;
  - a function returning the drain-counter width, clog2(COL+1).
- One sub-module: sa_wren_skew, a COL-stage shift register with a synchronous clear input, instantiated once.
- FSM and counters stay in the top module.

Test Plan:
- COL=3, i_len=4, start at cycle 10, FIFO never empty -> o_fifo_rd 11-14; o_col_wren[0] 12-15; [1] 13-16; [2] 14-17; o_busy 11-17; o_done at 18 only.
- Same as above, with i_fifo_empty=1 in cycle 12 only -> o_fifo_rd high 11 and 13-15; 0 on o_col_wren[0] at 13 and on [2] at 15; o_done at 19.
- i_start with i_len=0 -> o_err pulse next cycle, state stays IDLE, o_fifo_rd never asserts.
- i_start re-asserted during STREAM -> o_err pulse; original pass completes with unchanged timing and a single o_done.
- i_abort at cycle 13 of the first scenario -> o_fifo_rd=0 at 13; o_col_wren all 0 from 14; IDLE at 14; no o_done; new start at 15 runs normally.
- i_rst_n low mid-DRAIN -> all outputs 0 immediately (async); after release, a full pass with i_len=255 completes with exactly 255 reads.
